// File: rtl/arith_op_sequencer.sv
// Issues one multicycle op at a time to the add/sub/mul/div units and returns its result.
// Optional WAIT watchdog with err flag is enabled by defining ARITH_SEQ_TIMEOUT_EN.
module arith_op_sequencer #(
  parameter int DW  = 4,
  parameter int RW  = 8,
  parameter int TMO = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      opcode,
  input  logic [DW-1:0]   ain,
  input  logic [DW-1:0]   bin,
  output logic [1:0]      sel,
  output logic [DW-1:0]   adout,
  output logic [DW-1:0]   bdout,
  output logic [3:0]      unit_go,
  input  logic [3:0]      unit_done,
  input  logic [4*RW-1:0] unit_result,
  output logic            busy,
  output logic            done,
  output logic [RW-1:0]   result,
  output logic            err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  if (TMO < 1) begin : g_tmo_check
    $error("TMO must be at least 1");
  end

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot4 = 4'b0001;
      2'd1:    onehot4 = 4'b0010;
      2'd2:    onehot4 = 4'b0100;
      2'd3:    onehot4 = 4'b1000;
      default: onehot4 = 4'b0000;
    endcase
  endfunction

  function automatic logic [RW-1:0] pick_result(input logic [4*RW-1:0] bus,
                                                input logic [1:0]      idx);
    case (idx)
      2'd0:    pick_result = bus[0*RW +: RW];
      2'd1:    pick_result = bus[1*RW +: RW];
      2'd2:    pick_result = bus[2*RW +: RW];
      2'd3:    pick_result = bus[3*RW +: RW];
      default: pick_result = {RW{1'b0}};
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [DW-1:0]   adout_q, adout_d;
  logic [DW-1:0]   bdout_q, bdout_d;
  logic [3:0]      go_q, go_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [RW-1:0]   result_q, result_d;

  logic            accept_s;
  logic            hit_s;
  logic            tmo_s;
  logic [RW-1:0]   hit_result_s;

  // A request is only accepted when no operation is in flight.
  assign accept_s     = start & ((state_q == S_IDLE) | (state_q == S_FINISH));
  assign hit_s        = (state_q == S_WAIT) & unit_done[sel_q];
  assign hit_result_s = pick_result(unit_result, sel_q);

`ifdef ARITH_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

  logic [CW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  // Completion on the last allowed WAIT cycle takes priority over the timeout.
  assign tmo_s = (state_q == S_WAIT) & ~unit_done[sel_q] & (wdog_q == TMO_LAST);

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == S_ISSUE) begin
      wdog_d = {CW{1'b0}};
    end else if ((state_q == S_WAIT) && !unit_done[sel_q]) begin
      wdog_d = wdog_q + CW'(1);
    end else begin
      wdog_d = wdog_q;
    end
    if (accept_s) begin
      err_d = 1'b0;
    end else if (tmo_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= {CW{1'b0}};
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_s = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (hit_s || tmo_s) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FINISH: begin
        if (accept_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    sel_d    = sel_q;
    adout_d  = adout_q;
    bdout_d  = bdout_q;
    result_d = result_q;
    if (accept_s) begin
      sel_d   = opcode;
      adout_d = ain;
      bdout_d = bin;
    end else begin
      sel_d   = sel_q;
      adout_d = adout_q;
      bdout_d = bdout_q;
    end
    if (hit_s) begin
      result_d = hit_result_s;
    end else if (tmo_s) begin
      result_d = {RW{1'b1}};
    end else begin
      result_d = result_q;
    end
    if (state_d == S_ISSUE) begin
      go_d = onehot4(sel_d);
    end else begin
      go_d = 4'b0000;
    end
    busy_d = (state_d == S_ISSUE) | (state_d == S_WAIT);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 2'd0;
      adout_q  <= {DW{1'b0}};
      bdout_q  <= {DW{1'b0}};
      go_q     <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {RW{1'b0}};
    end else begin
      sel_q    <= sel_d;
      adout_q  <= adout_d;
      bdout_q  <= bdout_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign sel     = sel_q;
  assign adout   = adout_q;
  assign bdout   = bdout_q;
  assign unit_go = go_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Directed bench for arith_op_sequencer: vector table plus hand-written multi-cycle sequences.
// Four behavioural units answer each go pulse after a per-unit latency.
module tb_arith_op_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  opcode;
  logic [3:0]  ain;
  logic [3:0]  bin;
  logic [1:0]  sel;
  logic [3:0]  adout;
  logic [3:0]  bdout;
  logic [3:0]  unit_go;
  logic [3:0]  unit_done;
  logic [31:0] unit_result;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        err;

  int total;
  int bad;
  int pend;
  int pend_k;
  int lat_u [4];

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         lat;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  arith_op_sequencer #(.DW(4), .RW(8), .TMO(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .ain         (ain),
    .bin         (bin),
    .sel         (sel),
    .adout       (adout),
    .bdout       (bdout),
    .unit_go     (unit_go),
    .unit_done   (unit_done),
    .unit_result (unit_result),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] unit_calc(input int k, input logic [3:0] a, input logic [3:0] b);
    case (k)
      0:       return {4'h0, a} + {4'h0, b};
      1:       return {4'h0, a} - {4'h0, b};
      2:       return {4'h0, a} * {4'h0, b};
      default: return (b == 4'h0) ? 8'hFF : ({4'h0, a} / {4'h0, b});
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock; the unit models react to what the DUT shows just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    unit_done = 4'b0000;
    if (rst) begin
      pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) unit_done[pend_k] = 1'b1;
    end
    if (unit_go != 4'b0000 && !rst) begin
      for (int i = 3; i >= 0; i--) if (unit_go[i]) pend_k = i;
      pend = lat_u[pend_k];
      unit_result[pend_k*8 +: 8] = unit_calc(pend_k, adout, bdout);
    end
  endtask

  task automatic wait_done(input int n0, input int exp_n, input string nm);
    int n;
    n = n0;
    while (done !== 1'b1 && n < 80) begin
      step();
      n++;
      if (done !== 1'b1) begin
        chk({nm, "_busy_wait"}, busy, 1'b1);
        chk({nm, "_go_wait"}, unit_go, 4'b0000);
      end
    end
    chk({nm, "_done_cycle"}, n, exp_n);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int lat, input logic [7:0] exp_res, input logic exp_err,
                        input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << op;
    lat_u[op] = lat;
    start  = 1'b1;
    opcode = op;
    ain    = a;
    bin    = b;
    step();
    start  = 1'b0;
    opcode = ~op;
    ain    = ~a;
    bin    = ~b;
    chk({nm, "_go"}, unit_go, oh);
    chk({nm, "_sel_issue"}, sel, op);
    chk({nm, "_busy_issue"}, busy, 1'b1);
    chk({nm, "_done_issue"}, done, 1'b0);
    chk({nm, "_err_issue"}, err, 1'b0);
    wait_done(1, lat + 2, nm);
    chk({nm, "_result"}, result, exp_res);
    chk({nm, "_busy_fin"}, busy, 1'b0);
    chk({nm, "_adout"}, adout, a);
    chk({nm, "_bdout"}, bdout, b);
    chk({nm, "_sel_fin"}, sel, op);
    chk({nm, "_err_fin"}, err, exp_err);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pend  = 0;
    pend_k = 0;
    for (int i = 0; i < 4; i++) lat_u[i] = 1;
    rst         = 1'b1;
    start       = 1'b0;
    opcode      = 2'd0;
    ain         = 4'h0;
    bin         = 4'h0;
    unit_done   = 4'b0000;
    unit_result = 32'hA3B2C1D0;

    vecs[0] = '{2'd2, 4'h3, 4'h5, 4, 8'h0F};
    vecs[1] = '{2'd0, 4'h3, 4'h2, 1, 8'h05};
    vecs[2] = '{2'd3, 4'h9, 4'h2, 4, 8'h04};
    vecs[3] = '{2'd1, 4'h9, 4'h4, 2, 8'h05};
    vecs[4] = '{2'd0, 4'hF, 4'hF, 3, 8'h1E};
    vecs[5] = '{2'd2, 4'hF, 4'hF, 1, 8'hE1};
    vecs[6] = '{2'd1, 4'h2, 4'h5, 2, 8'hFD};
    vecs[7] = '{2'd3, 4'hF, 4'h3, 2, 8'h05};

    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_outs", {sel, adout, bdout, unit_go, busy, done, result, err}, 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].exp, 1'b0,
             $sformatf("vec%0d", i));
      step();
      chk($sformatf("vec%0d_done_once", i), done, 1'b0);
      chk($sformatf("vec%0d_hold", i), result, vecs[i].exp);
    end

    // Back-to-back: start held high, second request taken in the FINISH cycle.
    lat_u[0] = 1;
    lat_u[3] = 4;
    start = 1'b1; opcode = 2'd0; ain = 4'h3; bin = 4'h2;
    step();
    chk("b2b_go0", unit_go, 4'b0001);
    opcode = 2'd3; ain = 4'h9; bin = 4'h2;
    step();
    chk("b2b_sel_wait", sel, 2'd0);
    chk("b2b_adout_wait", adout, 4'h3);
    step();
    chk("b2b_done1", done, 1'b1);
    chk("b2b_res1", result, 8'h05);
    chk("b2b_busy_fin1", busy, 1'b0);
    step();
    start = 1'b0;
    chk("b2b_go3", unit_go, 4'b1000);
    chk("b2b_sel2", sel, 2'd3);
    chk("b2b_adout2", adout, 4'h9);
    chk("b2b_done_low", done, 1'b0);
    chk("b2b_res_held", result, 8'h05);
    wait_done(1, 6, "b2b2");
    chk("b2b_res2", result, 8'h04);
    step();

    // Stray done bit and a start during WAIT must both be ignored.
    lat_u[1] = 3;
    start = 1'b1; opcode = 2'd1; ain = 4'h7; bin = 4'h2;
    step();
    start = 1'b0;
    chk("ign_go", unit_go, 4'b0010);
    step();
    unit_done = unit_done | 4'b0001;
    start = 1'b1; opcode = 2'd3; ain = 4'h8; bin = 4'h1;
    step();
    start = 1'b0;
    chk("ign_sel", sel, 2'd1);
    chk("ign_busy", busy, 1'b1);
    chk("ign_done", done, 1'b0);
    chk("ign_go_none", unit_go, 4'b0000);
    wait_done(3, 5, "ign");
    chk("ign_res", result, 8'h05);
    chk("ign_sel_fin", sel, 2'd1);
    step();

    // Reset while waiting on the divider.
    lat_u[3] = 4;
    start = 1'b1; opcode = 2'd3; ain = 4'h8; bin = 4'h2;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_res", result, 8'h00);
    chk("mrst_go", unit_go, 4'b0000);
    chk("mrst_sel", sel, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst_no_done", done, 1'b0);
    end
    run_op(2'd3, 4'h8, 4'h2, 4, 8'h04, 1'b0, "mrst_fresh");
    step();

`ifdef ARITH_SEQ_TIMEOUT_EN
    lat_u[2] = 0;
    start = 1'b1; opcode = 2'd2; ain = 4'h1; bin = 4'h1;
    step();
    start = 1'b0;
    chk("tmo_go", unit_go, 4'b0100);
    wait_done(1, 17, "tmo");
    chk("tmo_res", result, 8'hFF);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    step();
    chk("tmo_err_sticky", err, 1'b1);
    chk("tmo_done_once", done, 1'b0);
    run_op(2'd2, 4'h2, 4'h3, 2, 8'h06, 1'b0, "tmo_clear");
    step();
    run_op(2'd0, 4'h4, 4'h5, 15, 8'h09, 1'b0, "tmo_edge");
    step();
`else
    lat_u[2] = 0;
    start = 1'b1; opcode = 2'd2; ain = 4'h1; bin = 4'h1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("notmo_busy", busy, 1'b1);
    chk("notmo_done", done, 1'b0);
    chk("notmo_err", err, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("notmo_rst_busy", busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
